// File: rtl/fp_pkg.sv
// Shared definitions for the 13-bit floating-point datapath and its seven-segment display.
package fp_pkg;

  localparam int unsigned FP_W     = 13;
  localparam int unsigned EXP_W    = 4;
  localparam int unsigned FRAC_W   = 8;
  localparam int unsigned SIGN_BIT = 12;
  localparam int unsigned EXP_MSB  = 11;
  localparam int unsigned EXP_LSB  = 8;

  localparam int unsigned NIB_W    = 4;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned AN_W     = 4;

  // Active-low {g,f,e,d,c,b,a} patterns for the non-hex glyphs.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_sseg
  import fp_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  output logic [SEG_W-1:0] seg_o_c
);

  always_comb begin
    seg_o_c = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o_c = 7'h40;
      4'h1: seg_o_c = 7'h79;
      4'h2: seg_o_c = 7'h24;
      4'h3: seg_o_c = 7'h30;
      4'h4: seg_o_c = 7'h19;
      4'h5: seg_o_c = 7'h12;
      4'h6: seg_o_c = 7'h02;
      4'h7: seg_o_c = 7'h78;
      4'h8: seg_o_c = 7'h00;
      4'h9: seg_o_c = 7'h10;
      4'hA: seg_o_c = 7'h08;
      4'hB: seg_o_c = 7'h03;
      4'hC: seg_o_c = 7'h46;
      4'hD: seg_o_c = 7'h21;
      4'hE: seg_o_c = 7'h06;
      4'hF: seg_o_c = 7'h0E;
      default: seg_o_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fp_sseg_driver.sv
// Four-digit multiplexed seven-segment display of a captured fp value (sign, exp, frac hex).
// Optional FP_SSEG_DP_EN lights the decimal point on the exponent digit.
module fp_sseg_driver
  import fp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [FP_W-1:0]   fp_in,
  output logic [AN_W-1:0]   an,
  output logic [SEG_W-1:0]  seg,
  output logic              dp
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [FP_W-1:0]  staged_q, staged_d;
  logic [FP_W-1:0]  shown_q, shown_d;
  logic             pending_q, pending_d;
  logic [AN_W-1:0]  an_q, an_d;
  logic [SEG_W-1:0] seg_q, seg_d;

  logic             cnt_wrap_c;
  logic             frame_end_c;
  logic             active_c;
  logic [NIB_W-1:0] nibble_c;
  logic [SEG_W-1:0] hex_seg_c;

  hex_to_sseg u_hex_to_sseg (
    .nibble_i (nibble_c),
    .seg_o_c  (hex_seg_c)
  );

  // Slot timing and frame-boundary update of the displayed value.
  always_comb begin
    cnt_wrap_c  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_end_c = cnt_wrap_c && (digit_q == 2'd3);
    cnt_d       = cnt_wrap_c ? '0 : cnt_q + CNT_W'(1);
    digit_d     = cnt_wrap_c ? digit_q + 2'd1 : digit_q;
    staged_d    = staged_q;
    pending_d   = pending_q;
    shown_d     = shown_q;
    if (load) begin
      staged_d  = fp_in;
      pending_d = 1'b1;
    end
    if (frame_end_c) begin
      pending_d = 1'b0;
      if (load) begin
        shown_d = fp_in;
      end else if (pending_q) begin
        shown_d = staged_q;
      end
    end
  end

  // Pin values are derived from post-edge state so the pins come straight from flops.
  always_comb begin
    active_c = (cnt_d >= CNT_W'(GUARD));
    nibble_c = '0;
    case (digit_d)
      2'd0:    nibble_c = shown_d[NIB_W-1:0];
      2'd1:    nibble_c = shown_d[FRAC_W-1:NIB_W];
      2'd2:    nibble_c = shown_d[EXP_MSB:EXP_LSB];
      default: nibble_c = '0;
    endcase
    an_d  = 4'hF;
    seg_d = SEG_BLANK;
    if (active_c) begin
      an_d = ~(4'b0001 << digit_d);
      if (digit_d == 2'd3) begin
        seg_d = shown_d[SIGN_BIT] ? SEG_MINUS : SEG_BLANK;
      end else begin
        seg_d = hex_seg_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      digit_q   <= '0;
      staged_q  <= '0;
      shown_q   <= '0;
      pending_q <= 1'b0;
      an_q      <= 4'hF;
      seg_q     <= SEG_BLANK;
    end else begin
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      staged_q  <= staged_d;
      shown_q   <= shown_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

`ifdef FP_SSEG_DP_EN
  logic dp_q, dp_d;

  // Decimal point marks the exponent/fraction split on digit 2.
  assign dp_d = ~(active_c && (digit_d == 2'd2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_q <= 1'b1;
    end else begin
      dp_q <= dp_d;
    end
  end

  assign dp = dp_q;
`else
  assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_fp_sseg_driver.sv
// Directed self-checking bench for fp_sseg_driver with REFRESH_DIV=8, GUARD=2.
module tb_fp_sseg_driver;

  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = 4 * RD;

  // Expected digit patterns packed as {d3, d2, d1, d0}.
  localparam logic [27:0] P_ZERO = {7'h7F, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] P_1A53 = {7'h3F, 7'h08, 7'h12, 7'h30};
  localparam logic [27:0] P_FFF  = {7'h7F, 7'h0E, 7'h0E, 7'h0E};
  localparam logic [27:0] P_456  = {7'h7F, 7'h19, 7'h12, 7'h02};

  logic        clk;
  logic        reset;
  logic        load;
  logic [12:0] fp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks;
  int fails;
  int pos;

  fp_sseg_driver #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .fp_in (fp_in),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release: slot position is pos % RD, digit is (pos / RD) % 4.
  always @(posedge clk or posedge reset) begin
    if (reset) pos <= 0;
    else       pos <= pos + 1;
  end

  function automatic logic [3:0] exp_an(input int p);
    int c, d;
    logic [3:0] a;
    c = p % RD;
    d = (p / RD) % 4;
    a = 4'hF;
    if (c >= GD) a[d] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_seg(input int p, input logic [27:0] pats);
    int c, d;
    c = p % RD;
    d = (p / RD) % 4;
    if (c < GD) return 7'h7F;
    return pats[d*7 +: 7];
  endfunction

  function automatic logic exp_dp(input int p);
`ifdef FP_SSEG_DP_EN
    return !(((p % RD) >= GD) && (((p / RD) % 4) == 2));
`else
    return 1'b1 | (p < 0);
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    load  = 1'b0;
    fp_in = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 3;
      if (an !== 4'hF) begin fails++; $display("FAIL reset_hold an got=%b exp=1111", an); end
      if (seg !== 7'h7F) begin fails++; $display("FAIL reset_hold seg got=%h exp=7f", seg); end
      if (dp !== 1'b1) begin fails++; $display("FAIL reset_hold dp got=%b exp=1", dp); end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks += 3;
      if (an !== exp_an(pos)) begin fails++; $display("FAIL reset_release an pos=%0d got=%b exp=%b", pos, an, exp_an(pos)); end
      if (seg !== exp_seg(pos, P_ZERO)) begin fails++; $display("FAIL reset_release seg pos=%0d got=%h exp=%h", pos, seg, exp_seg(pos, P_ZERO)); end
      if (dp !== exp_dp(pos)) begin fails++; $display("FAIL reset_release dp pos=%0d got=%b exp=%b", pos, dp, exp_dp(pos)); end
      @(negedge clk);
    end
  endtask

  task automatic test_load_boundary();
    int n;
    n = 0;
    while ((pos % FRAME) != FRAME - 1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2 * FRAME) begin fails++; $display("FAIL load_boundary align pos=%0d", pos); end
    load  = 1'b1;
    fp_in = 13'h1A53;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      checks += 3;
      if (an !== exp_an(pos)) begin fails++; $display("FAIL load_boundary an pos=%0d got=%b exp=%b", pos, an, exp_an(pos)); end
      if (seg !== exp_seg(pos, P_1A53)) begin fails++; $display("FAIL load_boundary seg pos=%0d got=%h exp=%h", pos, seg, exp_seg(pos, P_1A53)); end
      if (dp !== exp_dp(pos)) begin fails++; $display("FAIL load_boundary dp pos=%0d got=%b exp=%b", pos, dp, exp_dp(pos)); end
      @(negedge clk);
    end
  endtask

  task automatic test_anti_tearing();
    logic [27:0] p;
    for (int i = 0; i < 2 * FRAME; i++) begin
      p = (i < FRAME) ? P_1A53 : P_FFF;
      checks += 3;
      if (an !== exp_an(pos)) begin fails++; $display("FAIL anti_tearing an pos=%0d got=%b exp=%b", pos, an, exp_an(pos)); end
      if (seg !== exp_seg(pos, p)) begin fails++; $display("FAIL anti_tearing seg pos=%0d got=%h exp=%h", pos, seg, exp_seg(pos, p)); end
      if (dp !== exp_dp(pos)) begin fails++; $display("FAIL anti_tearing dp pos=%0d got=%b exp=%b", pos, dp, exp_dp(pos)); end
      load  = (i == RD + 2);
      fp_in = 13'h0FFF;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_last_wins();
    logic [27:0] p;
    for (int i = 0; i < 2 * FRAME; i++) begin
      p = (i < FRAME) ? P_FFF : P_456;
      checks += 3;
      if (an !== exp_an(pos)) begin fails++; $display("FAIL last_wins an pos=%0d got=%b exp=%b", pos, an, exp_an(pos)); end
      if (seg !== exp_seg(pos, p)) begin fails++; $display("FAIL last_wins seg pos=%0d got=%h exp=%h", pos, seg, exp_seg(pos, p)); end
      if (dp !== exp_dp(pos)) begin fails++; $display("FAIL last_wins dp pos=%0d got=%b exp=%b", pos, dp, exp_dp(pos)); end
      load  = (i == 4) || (i == 20);
      fp_in = (i == 4) ? 13'h0123 : 13'h0456;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2 * RD + 2; i++) begin
      checks += 2;
      if (an !== exp_an(pos)) begin fails++; $display("FAIL reset_mid_pre an pos=%0d got=%b exp=%b", pos, an, exp_an(pos)); end
      if (seg !== exp_seg(pos, P_456)) begin fails++; $display("FAIL reset_mid_pre seg pos=%0d got=%h exp=%h", pos, seg, exp_seg(pos, P_456)); end
      load  = (i == 3);
      fp_in = 13'h0789;
      @(negedge clk);
    end
    load = 1'b0;
    checks++;
    if (an !== 4'b1011) begin fails++; $display("FAIL reset_mid_digit2 an got=%b exp=1011", an); end
    reset = 1'b1;
    #1;
    checks += 3;
    if (an !== 4'hF) begin fails++; $display("FAIL reset_mid_async an got=%b exp=1111", an); end
    if (seg !== 7'h7F) begin fails++; $display("FAIL reset_mid_async seg got=%h exp=7f", seg); end
    if (dp !== 1'b1) begin fails++; $display("FAIL reset_mid_async dp got=%b exp=1", dp); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      checks += 3;
      if (an !== exp_an(pos)) begin fails++; $display("FAIL reset_mid_post an pos=%0d got=%b exp=%b", pos, an, exp_an(pos)); end
      if (seg !== exp_seg(pos, P_ZERO)) begin fails++; $display("FAIL reset_mid_post seg pos=%0d got=%h exp=%h", pos, seg, exp_seg(pos, P_ZERO)); end
      if (dp !== exp_dp(pos)) begin fails++; $display("FAIL reset_mid_post dp pos=%0d got=%b exp=%b", pos, dp, exp_dp(pos)); end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    load   = 1'b0;
    fp_in  = '0;
    test_reset();
    test_load_boundary();
    test_anti_tearing();
    test_last_wins();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
